// File: rtl/deadtime_pkg.sv
// Shared types and defaults for the half-bridge dead-time controller.
package deadtime_pkg;

    localparam int NUM_CH_DEF = 3;
    localparam int DT_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEAD   = 2'd1,
        ST_DRV_HI = 2'd2,
        ST_DRV_LO = 2'd3
    } ch_state_t;

    // Drive state reached once the dead interval expires; 11 is treated as 00.
    function automatic ch_state_t drive_state(input logic hi, input logic lo);
        case ({hi, lo})
            2'b10:   drive_state = ST_DRV_HI;
            2'b01:   drive_state = ST_DRV_LO;
            default: drive_state = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/deadtime_ch.sv
// One half-bridge channel: request synchronizer, dead-time counter and gate FSM.
//   state     | meaning
//   ST_IDLE   | both gates off, no request or held off by the top level
//   ST_DEAD   | both gates off, counting the dead interval
//   ST_DRV_HI | high-side gate on
//   ST_DRV_LO | low-side gate on
module deadtime_ch
    import deadtime_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    input  logic            restart,
    input  logic [DT_W-1:0] dt_cycles,
    input  logic            hi_req,
    input  logic            lo_req,
    output logic            hi_sync,
    output logic            lo_sync,
    output logic            hi_out,
    output logic            lo_out,
    output logic            dead_active
);

    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      prev;
    logic            change;
    ch_state_t       state;
    ch_state_t       next_state;
    logic [DT_W-1:0] count;
    logic [DT_W-1:0] count_next;
    logic [DT_W-1:0] dt_lat;
    logic [DT_W-1:0] dt_lat_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            prev  <= 2'b00;
        end else begin
            sync1 <= {hi_req, lo_req};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign change  = (sync2 != prev);
    assign hi_sync = sync2[1];
    assign lo_sync = sync2[0];

    always_comb begin
        next_state  = state;
        count_next  = count;
        dt_lat_next = dt_lat;
        if (hold) begin
            next_state = ST_IDLE;
            count_next = '0;
        end else if (restart || change) begin
            next_state  = ST_DEAD;
            count_next  = '0;
            dt_lat_next = dt_cycles;
        end else if (state == ST_DEAD) begin
            // The counter stops at the latched value, so it can never wrap.
            if (count == dt_lat) begin
                next_state = drive_state(sync2[1], sync2[0]);
                count_next = '0;
            end else begin
                count_next = count + {{(DT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            count       <= '0;
            dt_lat      <= '0;
            hi_out      <= 1'b0;
            lo_out      <= 1'b0;
            dead_active <= 1'b0;
        end else begin
            state       <= next_state;
            count       <= count_next;
            dt_lat      <= dt_lat_next;
            hi_out      <= (next_state == ST_DRV_HI);
            lo_out      <= (next_state == ST_DRV_LO);
            dead_active <= (next_state == ST_DEAD);
        end
    end

endmodule

// File: rtl/deadtime_ctrl.sv
// Multi-channel dead-time controller: enable/fault gating around per-channel FSMs.
// Shoot-through detection is built when DEADTIME_SHOOT_THRU_DET_EN is defined.
module deadtime_ctrl
    import deadtime_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DT_W   = DT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DT_W-1:0]   dt_cycles,
    input  logic [NUM_CH-1:0] hi_req,
    input  logic [NUM_CH-1:0] lo_req,
    input  logic              clr_fault,
    output logic [NUM_CH-1:0] hi_out,
    output logic [NUM_CH-1:0] lo_out,
    output logic [NUM_CH-1:0] dead_active,
    output logic              fault
);

    logic [NUM_CH-1:0] hi_sync;
    logic [NUM_CH-1:0] lo_sync;
    logic              fault_next;
    logic              gate_next;
    logic              gate_q;
    logic              hold;
    logic              restart;

`ifdef DEADTIME_SHOOT_THRU_DET_EN
    logic fault_set;
    logic fault_q;

    // A set in the same cycle as a clear keeps the fault asserted.
    assign fault_set  = |(hi_sync & lo_sync);
    assign fault_next = fault_set | (fault_q & ~clr_fault);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_next;
        end
    end

    assign fault = fault_q;
`else
    logic unused_ok;
    assign unused_ok  = ^{hi_sync, lo_sync, clr_fault};
    assign fault_next = 1'b0;
    assign fault      = 1'b0;
`endif

    // Channels are released on the same edge the gate opens, entering DEAD.
    assign gate_next = en & ~fault_next;
    assign hold      = ~gate_next;
    assign restart   = gate_next & ~gate_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q <= 1'b0;
        end else begin
            gate_q <= gate_next;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        deadtime_ch #(
            .DT_W(DT_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .hold       (hold),
            .restart    (restart),
            .dt_cycles  (dt_cycles),
            .hi_req     (hi_req[i]),
            .lo_req     (lo_req[i]),
            .hi_sync    (hi_sync[i]),
            .lo_sync    (lo_sync[i]),
            .hi_out     (hi_out[i]),
            .lo_out     (lo_out[i]),
            .dead_active(dead_active[i])
        );
    end

endmodule

// File: tb/tb_deadtime_ctrl.sv
// Scoreboard bench for deadtime_ctrl: directed request sequences, timed expectations.
module tb_deadtime_ctrl;

    localparam int NUM_CH = 3;
    localparam int DT_W   = 8;
    localparam int S_HI   = 0;
    localparam int S_LO   = 1;
    localparam int S_DEAD = 2;
    localparam int S_FLT  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [DT_W-1:0]   dt_cycles;
    logic [NUM_CH-1:0] hi_req;
    logic [NUM_CH-1:0] lo_req;
    logic              clr_fault;
    logic [NUM_CH-1:0] hi_out;
    logic [NUM_CH-1:0] lo_out;
    logic [NUM_CH-1:0] dead_active;
    logic              fault;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int    cyc;
        int    sig;
        int    ch;
        logic  val;
        string name;
    } exp_t;

    exp_t sb[$];

    deadtime_ctrl #(.NUM_CH(NUM_CH), .DT_W(DT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .dt_cycles  (dt_cycles),
        .hi_req     (hi_req),
        .lo_req     (lo_req),
        .clr_fault  (clr_fault),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .dead_active(dead_active),
        .fault      (fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic get_sig(input int sig, input int ch);
        case (sig)
            S_HI:    get_sig = hi_out[ch];
            S_LO:    get_sig = lo_out[ch];
            S_DEAD:  get_sig = dead_active[ch];
            default: get_sig = fault;
        endcase
    endfunction

    task automatic sb_push(input int c, input int sig, input int ch, input logic v, input string name);
        exp_t e;
        e.cyc  = c;
        e.sig  = sig;
        e.ch   = ch;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d expectations left, next %s at cycle %0d", sb.size(), sb[0].name, sb[0].cyc);
            sb.delete();
        end
    endtask

    // Monitor: overlap check every cycle, plus every expectation due now.
    always @(negedge clk) begin : monitor
        exp_t e;
        chk("no_overlap", |(hi_out & lo_out), 1'b0);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: missed at cycle %0d (due %0d)", e.name, cyc, e.cyc);
            end else begin
                chk(e.name, get_sig(e.sig, e.ch), e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k0, k1, k2, c, e, r;
        rst_n     = 1'b0;
        en        = 1'b1;
        dt_cycles = '0;
        hi_req    = '0;
        lo_req    = '0;
        clr_fault = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_hi", |hi_out, 1'b0);
        chk("rst_lo", |lo_out, 1'b0);
        chk("rst_dead", |dead_active, 1'b0);
        chk("rst_fault", fault, 1'b0);

        // Release: one restart DEAD interval (dt=0), then IDLE.
        @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
        sb_push(c + 1, S_DEAD, 0, 1'b1, "post_rst_dead");
        sb_push(c + 2, S_DEAD, 0, 1'b0, "post_rst_idle");
        sb_push(c + 2, S_HI,   0, 1'b0, "post_rst_hi");
        drain(20);

        // dt=5, ch0 00->10.
        @(negedge clk);
        dt_cycles = 8'd5;
        hi_req[0] = 1'b1;
        k = cyc + 1;
        sb_push(k + 1, S_DEAD, 0, 1'b0, "t1_dead_pre");
        sb_push(k + 2, S_DEAD, 0, 1'b1, "t1_dead_first");
        sb_push(k + 7, S_DEAD, 0, 1'b1, "t1_dead_last");
        sb_push(k + 7, S_HI,   0, 1'b0, "t1_hi_low");
        sb_push(k + 8, S_DEAD, 0, 1'b0, "t1_dead_end");
        sb_push(k + 8, S_HI,   0, 1'b1, "t1_hi_rise");
        drain(30);

        // dt=0, ch1 00->10 then 10->01.
        @(negedge clk);
        dt_cycles = 8'd0;
        hi_req[1] = 1'b1;
        k = cyc + 1;
        sb_push(k + 2, S_DEAD, 1, 1'b1, "t2a_dead");
        sb_push(k + 2, S_HI,   1, 1'b0, "t2a_hi_low");
        sb_push(k + 3, S_HI,   1, 1'b1, "t2a_hi_rise");
        drain(20);
        @(negedge clk);
        hi_req[1] = 1'b0;
        lo_req[1] = 1'b1;
        k = cyc + 1;
        sb_push(k + 1, S_HI,   1, 1'b1, "t2_hi_hold");
        sb_push(k + 2, S_HI,   1, 1'b0, "t2_hi_fall");
        sb_push(k + 2, S_LO,   1, 1'b0, "t2_lo_low");
        sb_push(k + 2, S_DEAD, 1, 1'b1, "t2_dead");
        sb_push(k + 3, S_LO,   1, 1'b1, "t2_lo_rise");
        sb_push(k + 3, S_DEAD, 1, 1'b0, "t2_dead_end");
        drain(20);

        // dt=10, ch2 10 -> 01 -> 10, changes 4 clocks apart.
        @(negedge clk);
        dt_cycles = 8'd10;
        hi_req[2] = 1'b1;
        k0 = cyc + 1;
        sb_push(k0 + 2, S_DEAD, 2, 1'b1, "t3_dead0");
        sb_push(k0 + 3, S_DEAD, 2, 1'b1, "t3_dead0b");
        repeat (4) @(negedge clk);
        hi_req[2] = 1'b0;
        lo_req[2] = 1'b1;
        k1 = cyc + 1;
        sb_push(k1 + 2, S_DEAD, 2, 1'b1, "t3_dead1");
        sb_push(k1 + 3, S_LO,   2, 1'b0, "t3_lo_low1");
        sb_push(k1 + 3, S_HI,   2, 1'b0, "t3_hi_low1");
        repeat (4) @(negedge clk);
        hi_req[2] = 1'b1;
        lo_req[2] = 1'b0;
        k2 = cyc + 1;
        sb_push(k2 + 5,  S_HI,   2, 1'b0, "t3_no_early_drive");
        sb_push(k2 + 5,  S_DEAD, 2, 1'b1, "t3_dead_restart");
        sb_push(k2 + 12, S_HI,   2, 1'b0, "t3_hi_low_last");
        sb_push(k2 + 12, S_DEAD, 2, 1'b1, "t3_dead_last");
        sb_push(k2 + 13, S_HI,   2, 1'b1, "t3_hi_rise");
        sb_push(k2 + 13, S_DEAD, 2, 1'b0, "t3_dead_end");
        drain(40);

`ifdef DEADTIME_SHOOT_THRU_DET_EN
        // ch0 11: fault, everything held off.
        @(negedge clk);
        lo_req[0] = 1'b1;
        k = cyc + 1;
        sb_push(k + 1, S_FLT,  0, 1'b0, "t4_fault_pre");
        sb_push(k + 2, S_FLT,  0, 1'b1, "t4_fault_set");
        sb_push(k + 2, S_HI,   0, 1'b0, "t4_hi0_off");
        sb_push(k + 2, S_LO,   1, 1'b0, "t4_lo1_off");
        sb_push(k + 2, S_HI,   2, 1'b0, "t4_hi2_off");
        sb_push(k + 2, S_DEAD, 0, 1'b0, "t4_dead0_off");
        drain(20);
        @(negedge clk);
        hi_req[0] = 1'b0;
        dt_cycles = 8'd3;
        c = cyc + 4;
        sb_push(c, S_FLT, 0, 1'b1, "t4_fault_sticky");
        sb_push(c, S_LO,  0, 1'b0, "t4_lo0_held");
        repeat (4) @(negedge clk);
        clr_fault = 1'b1;
        c = cyc;
        sb_push(c + 1, S_FLT,  0, 1'b0, "t4_fault_clr");
        sb_push(c + 1, S_DEAD, 0, 1'b1, "t4_dead_after_clr");
        sb_push(c + 4, S_LO,   0, 1'b0, "t4_lo0_low");
        sb_push(c + 5, S_LO,   0, 1'b1, "t4_lo0_rise");
        sb_push(c + 5, S_LO,   1, 1'b1, "t4_lo1_rise");
        sb_push(c + 5, S_HI,   2, 1'b1, "t4_hi2_rise");
        @(negedge clk);
        clr_fault = 1'b0;
        drain(20);
`else
        // ch0 11 without detection: DEAD then IDLE, fault stays 0.
        @(negedge clk);
        dt_cycles = 8'd1;
        lo_req[0] = 1'b1;
        k = cyc + 1;
        sb_push(k + 2, S_DEAD, 0, 1'b1, "t4_dead");
        sb_push(k + 2, S_HI,   0, 1'b0, "t4_hi0_off");
        sb_push(k + 3, S_DEAD, 0, 1'b1, "t4_dead2");
        sb_push(k + 4, S_DEAD, 0, 1'b0, "t4_idle_dead");
        sb_push(k + 4, S_HI,   0, 1'b0, "t4_idle_hi");
        sb_push(k + 4, S_LO,   0, 1'b0, "t4_idle_lo");
        sb_push(k + 4, S_FLT,  0, 1'b0, "t4_no_fault");
        sb_push(k + 4, S_HI,   2, 1'b1, "t4_ch2_keep");
        drain(20);
        @(negedge clk);
        hi_req[0] = 1'b0;
        dt_cycles = 8'd3;
        k = cyc + 1;
        sb_push(k + 5, S_LO,   0, 1'b0, "t4_lo0_low");
        sb_push(k + 5, S_DEAD, 0, 1'b1, "t4_lo0_dead");
        sb_push(k + 6, S_LO,   0, 1'b1, "t4_lo0_rise");
        drain(20);
`endif

        // en low while all drive, then back on with dt=2.
        @(negedge clk);
        en = 1'b0;
        c = cyc;
        sb_push(c + 1, S_LO,   0, 1'b0, "t5_lo0_off");
        sb_push(c + 1, S_LO,   1, 1'b0, "t5_lo1_off");
        sb_push(c + 1, S_HI,   2, 1'b0, "t5_hi2_off");
        sb_push(c + 1, S_DEAD, 0, 1'b0, "t5_dead0_off");
        drain(20);
        @(negedge clk);
        dt_cycles = 8'd2;
        repeat (2) @(negedge clk);
        en = 1'b1;
        e = cyc;
        sb_push(e + 1, S_DEAD, 0, 1'b1, "t5_dead0");
        sb_push(e + 1, S_DEAD, 1, 1'b1, "t5_dead1");
        sb_push(e + 1, S_DEAD, 2, 1'b1, "t5_dead2");
        sb_push(e + 3, S_LO,   0, 1'b0, "t5_lo0_low");
        sb_push(e + 4, S_LO,   0, 1'b1, "t5_lo0_rise");
        sb_push(e + 4, S_LO,   1, 1'b1, "t5_lo1_rise");
        sb_push(e + 4, S_HI,   2, 1'b1, "t5_hi2_rise");
        drain(20);

        // dt=200, reset mid-DEAD, then full interval after release.
        @(negedge clk);
        dt_cycles = 8'd200;
        hi_req[0] = 1'b1;
        lo_req[0] = 1'b0;
        k = cyc + 1;
        sb_push(k + 2,  S_DEAD, 0, 1'b1, "t6_dead");
        sb_push(k + 40, S_DEAD, 0, 1'b1, "t6_dead_mid");
        sb_push(k + 40, S_HI,   0, 1'b0, "t6_hi_low");
        drain(60);
        while (cyc < k + 50) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_hi", |hi_out, 1'b0);
        chk("t6_async_lo", |lo_out, 1'b0);
        chk("t6_async_dead", |dead_active, 1'b0);
        chk("t6_async_fault", fault, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r = cyc + 1;
        sb_push(r,       S_DEAD, 0, 1'b1, "t6_rel_dead");
        sb_push(r + 1,   S_DEAD, 0, 1'b1, "t6_rel_dead1");
        sb_push(r + 100, S_DEAD, 0, 1'b1, "t6_dt_change_ignored");
        sb_push(r + 202, S_HI,   0, 1'b0, "t6_hi_low_last");
        sb_push(r + 202, S_DEAD, 0, 1'b1, "t6_dead_last");
        sb_push(r + 203, S_HI,   0, 1'b1, "t6_hi0_rise");
        sb_push(r + 203, S_DEAD, 0, 1'b0, "t6_dead_end");
        sb_push(r + 203, S_LO,   1, 1'b1, "t6_lo1_rise");
        sb_push(r + 203, S_HI,   2, 1'b1, "t6_hi2_rise");
        while (cyc < r + 50) @(negedge clk);
        dt_cycles = 8'd5;
        drain(300);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deadtime_ctrl.md
DEADTIME_CTRL -- requirements
Module: deadtime_ctrl

Interface
REQ-001 Parameter NUM_CH, default 3: number of half-bridge channels (one per motor phase).
REQ-002 Parameter DT_W, default 8: width of the dead-time count and of the dt_cycles input.
REQ-003 clk  input  1  system clock; every flop is rising-edge triggered.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  global enable; low forces every gate output low.
REQ-006 dt_cycles  input  DT_W  programmable dead time, in clocks.
REQ-007 hi_req  input  NUM_CH  high-side drive request per channel (asynchronous to clk).
REQ-008 lo_req  input  NUM_CH  low-side drive request per channel (asynchronous to clk).
REQ-009 clr_fault  input  1  single-cycle pulse that clears the shoot-through fault.
REQ-010 hi_out  output  NUM_CH  registered high-side gate drive.
REQ-011 lo_out  output  NUM_CH  registered low-side gate drive.
REQ-012 dead_active  output  NUM_CH  high while the channel is in the DEAD state.
REQ-013 fault  output  1  sticky shoot-through fault flag.

Function
REQ-014 Each request bit shall pass through a two-flop synchronizer; a third flop (prev) shall hold the last synchronized pair; change = sync2 != prev.
REQ-015 Each channel shall have an FSM with states IDLE, DEAD, DRV_HI, DRV_LO; hi_out = (state==DRV_HI), lo_out = (state==DRV_LO), both registered.
REQ-016 Any change in a channel's synchronized request pair, from any state, shall move that channel to DEAD, clear its counter to 0 and latch dt_cycles.
REQ-017 In DEAD the counter shall increment by 1 per clock; when count == latched dt, the next state shall be DRV_HI for pair 10, DRV_LO for 01, and IDLE for 00.
REQ-018 Timing: a request stable before edge k gives outputs low after edge k+2, and the new drive after edge k+3+dt.
REQ-019 The dead (both-low) interval shall be exactly dt+1 clocks; dt_cycles=0 still gives 1 dead clock.
REQ-020 A request change during DEAD shall restart the count from 0 and re-latch dt_cycles.
REQ-021 Changes to dt_cycles mid-DEAD shall be ignored until the next entry to DEAD.
REQ-022 The counter shall be DT_W bits and shall never wrap, because it stops at the latched dt.
REQ-023 Channels shall be independent; simultaneous changes on several channels shall each follow REQ-016 to REQ-019.
REQ-024 With en low, every channel shall be held in IDLE with its counter at 0.
REQ-025 On the clock after en rises, every channel shall enter DEAD (treated as a change).

Reset
REQ-026 During rst_n low, all synchronizer, prev and counter flops shall be 0, all FSMs IDLE, and hi_out, lo_out, dead_active and fault shall be 0.
REQ-027 After reset deasserts, a channel shall drive only after a full dead interval per REQ-018.
REQ-028 Reset asserted mid-DEAD or mid-drive shall force all outputs low immediately, with no clock required.

Configuration
REQ-029 Macro DEADTIME_SHOOT_THRU_DET_EN controls shoot-through detection.
REQ-030 When DEADTIME_SHOOT_THRU_DET_EN is defined, a synchronized pair of 11 on any channel shall set fault on the next edge.
REQ-031 When DEADTIME_SHOOT_THRU_DET_EN is defined, all channels shall be held in IDLE while fault=1.
REQ-032 When DEADTIME_SHOOT_THRU_DET_EN is defined, clr_fault shall clear fault, and set shall win over a simultaneous clear.
REQ-033 When DEADTIME_SHOOT_THRU_DET_EN is defined, once fault clears each channel shall enter DEAD.
REQ-034 When DEADTIME_SHOOT_THRU_DET_EN is undefined, fault shall be tied to 0 and a pair of 11 shall behave as 00 (DEAD then IDLE).

Structure
REQ-035 Package deadtime_pkg shall hold the state enum typedef and the NUM_CH/DT_W default constants.
REQ-036 Sub-module deadtime_ch shall contain one channel's synchronizer, FSM and counter, instantiated NUM_CH times.
REQ-037 The top level shall hold only the fault logic and the en/fault gating.

Verification
REQ-038 dt_cycles=5, ch0 request 00->10 at edge k: hi_out[0] stays 0 through edge k+8 and goes 1 after edge k+8; dead_active[0] is high for 6 clocks.
REQ-039 dt_cycles=0, ch1 request 10->01: hi_out[1] falls after edge k+2, lo_out[1] rises after edge k+3, and hi_out/lo_out are never both 1.
REQ-040 dt_cycles=10, ch2 request toggles 10->01->10 with changes 4 clocks apart: the count restarts each time, and ch2 drives only 11 clocks after the last change.
REQ-041 With DEADTIME_SHOOT_THRU_DET_EN defined, ch0 request 11: fault=1 and all outputs stay 0; clr_fault, then request 01 with dt=3: lo_out[0] rises 4 clocks after the clear.
REQ-042 en deasserted while all channels are driving: all outputs go 0 on the next edge; en reasserted with dt=2: all channels drive again 3 clocks after entering DEAD.
REQ-043 rst_n asserted mid-DEAD with dt=200: outputs are 0 asynchronously, and after release the full 201-clock dead interval is observed.
